// File: rtl/router_fifo_rr.sv
// NUM_PORTS x NUM_PORTS packet router: one circular FIFO per input and one
// registered round-robin arbiter per output. Both sides use valid/ready handshakes.
module router_fifo_rr #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned DEST_W    = $clog2(NUM_PORTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data   [NUM_PORTS-1:0],
  input  logic [DEST_W-1:0]     in_dest   [NUM_PORTS-1:0],
  input  logic [NUM_PORTS-1:0]  in_valid,
  output logic [NUM_PORTS-1:0]  in_ready,
  output logic [DATA_WIDTH-1:0] out_data  [NUM_PORTS-1:0],
  output logic [DEST_W-1:0]     out_src   [NUM_PORTS-1:0],
  output logic [NUM_PORTS-1:0]  out_valid,
  input  logic [NUM_PORTS-1:0]  out_ready
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [DEST_W+DATA_WIDTH-1:0] entry_t;

  entry_t                mem_q      [NUM_PORTS-1:0][FIFO_DEPTH-1:0];
  logic [PtrW-1:0]       wr_ptr_q   [NUM_PORTS-1:0];
  logic [PtrW-1:0]       rd_ptr_q   [NUM_PORTS-1:0];
  logic [CntW-1:0]       cnt_q      [NUM_PORTS-1:0];
  logic [CntW-1:0]       cnt_d      [NUM_PORTS-1:0];

  logic [NUM_PORTS-1:0]  full;
  logic [NUM_PORTS-1:0]  not_empty;
  logic [NUM_PORTS-1:0]  push;
  logic [NUM_PORTS-1:0]  pop;
  logic [DEST_W-1:0]     head_dest  [NUM_PORTS-1:0];
  logic [DATA_WIDTH-1:0] head_data  [NUM_PORTS-1:0];

  logic [NUM_PORTS-1:0]  grant;
  logic [DEST_W-1:0]     gnt_idx    [NUM_PORTS-1:0];
  logic [DEST_W-1:0]     cand;

  logic [DEST_W-1:0]     rr_ptr_q   [NUM_PORTS-1:0];
  logic [DEST_W-1:0]     rr_ptr_d   [NUM_PORTS-1:0];
  logic [NUM_PORTS-1:0]  out_valid_q;
  logic [NUM_PORTS-1:0]  out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q [NUM_PORTS-1:0];
  logic [DATA_WIDTH-1:0] out_data_d [NUM_PORTS-1:0];
  logic [DEST_W-1:0]     out_src_q  [NUM_PORTS-1:0];
  logic [DEST_W-1:0]     out_src_d  [NUM_PORTS-1:0];

  // FIFO status depends on the count only, so a full FIFO refuses a push even while popping.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      full[i]      = (cnt_q[i] == CntW'(FIFO_DEPTH));
      not_empty[i] = (cnt_q[i] != '0);
      push[i]      = in_valid[i] && !full[i];
      {head_dest[i], head_data[i]} = mem_q[i][rd_ptr_q[i]];
      cnt_d[i]     = cnt_q[i] + CntW'(push[i]) - CntW'(pop[i]);
    end
  end

  assign in_ready = ~full;

  // Per output: scan inputs starting one past the last winner, wrapping around.
  always_comb begin
    cand = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      grant[j]   = 1'b0;
      gnt_idx[j] = '0;
      if (!out_valid_q[j] || out_ready[j]) begin
        for (int k = 1; k <= NUM_PORTS; k++) begin
          cand = rr_ptr_q[j] + DEST_W'(k);
          if (!grant[j] && not_empty[cand] && (head_dest[cand] == DEST_W'(j))) begin
            grant[j]   = 1'b1;
            gnt_idx[j] = cand;
          end
        end
      end
    end
  end

  // A head has a single destination, so at most one output pops any given input.
  always_comb begin
    pop = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (grant[j]) begin
        pop[gnt_idx[j]] = 1'b1;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    for (int j = 0; j < NUM_PORTS; j++) begin
      out_data_d[j] = out_data_q[j];
      out_src_d[j]  = out_src_q[j];
      rr_ptr_d[j]   = rr_ptr_q[j];
      if (grant[j]) begin
        out_valid_d[j] = 1'b1;
        out_data_d[j]  = head_data[gnt_idx[j]];
        out_src_d[j]   = gnt_idx[j];
        rr_ptr_d[j]    = gnt_idx[j];
      end else if (out_ready[j]) begin
        out_valid_d[j] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (push[i]) begin
          wr_ptr_q[i] <= wr_ptr_q[i] + PtrW'(1);
        end
        if (pop[i]) begin
          rd_ptr_q[i] <= rd_ptr_q[i] + PtrW'(1);
        end
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Storage needs no reset: pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= {in_dest[i], in_data[i]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= '0;
      for (int j = 0; j < NUM_PORTS; j++) begin
        out_data_q[j] <= '0;
        out_src_q[j]  <= '0;
        rr_ptr_q[j]   <= DEST_W'(NUM_PORTS - 1);
      end
    end else begin
      out_valid_q <= out_valid_d;
      for (int j = 0; j < NUM_PORTS; j++) begin
        out_data_q[j] <= out_data_d[j];
        out_src_q[j]  <= out_src_d[j];
        rr_ptr_q[j]   <= rr_ptr_d[j];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule
